// File: rtl/rtttl_pkg.sv
// Shared RTTTL constants: clock rate, octave-4 half-period table, key codes, tone FSM states.
package rtttl_pkg;

  localparam int unsigned CLK_HZ = 1_000_000;
  localparam int unsigned BASE_W = 11;

  typedef logic [BASE_W-1:0] base_t;

  localparam logic [15:0] KEY_REST = 16'd0;
  localparam logic [15:0] KEY_C    = 16'd1;
  localparam logic [15:0] KEY_CS   = 16'd2;
  localparam logic [15:0] KEY_D    = 16'd3;
  localparam logic [15:0] KEY_DS   = 16'd4;
  localparam logic [15:0] KEY_E    = 16'd5;
  localparam logic [15:0] KEY_F    = 16'd6;
  localparam logic [15:0] KEY_FS   = 16'd7;
  localparam logic [15:0] KEY_G    = 16'd8;
  localparam logic [15:0] KEY_GS   = 16'd9;
  localparam logic [15:0] KEY_A    = 16'd10;
  localparam logic [15:0] KEY_AS   = 16'd11;
  localparam logic [15:0] KEY_B    = 16'd12;

  localparam logic [3:0] OCT_MIN = 4'd4;
  localparam logic [3:0] OCT_MAX = 4'd7;

  typedef logic [1:0] state_t;
  localparam state_t SILENT = 2'd0;
  localparam state_t GAP    = 2'd1;
  localparam state_t PLAY   = 2'd2;

  // Octave-4 half-period in 1 MHz cycles, indexed by key-1 (C..B).
  function automatic base_t base_hp(input logic [3:0] idx);
    case (idx)
      4'd0:    base_hp = 11'd1911;
      4'd1:    base_hp = 11'd1804;
      4'd2:    base_hp = 11'd1703;
      4'd3:    base_hp = 11'd1607;
      4'd4:    base_hp = 11'd1517;
      4'd5:    base_hp = 11'd1432;
      4'd6:    base_hp = 11'd1351;
      4'd7:    base_hp = 11'd1276;
      4'd8:    base_hp = 11'd1204;
      4'd9:    base_hp = 11'd1136;
      4'd10:   base_hp = 11'd1073;
      4'd11:   base_hp = 11'd1012;
      default: base_hp = 11'd0;
    endcase
  endfunction

endpackage

// File: rtl/rtttl_tone_gen_if.sv
// Pitch-code input and speaker-drive output bundle between sequencer and tone generator.
interface rtttl_tone_gen_if;
  logic        enable;
  logic [3:0]  octave;
  logic [15:0] note;
  logic        tone_out;
  logic        tone_active;

  modport master (output enable, octave, note, input tone_out, tone_active);
  modport slave  (input enable, octave, note, output tone_out, tone_active);
endinterface

// File: rtl/rtttl_pitch_lut.sv
// Combinational (octave, note) -> {sounding, half_period}; octaves clamp to 4..7.
module rtttl_pitch_lut
  import rtttl_pkg::*;
#(
  parameter int unsigned HP_W = 11
) (
  input  logic [3:0]      octave,
  input  logic [15:0]     note,
  output logic            sounding,
  output logic [HP_W-1:0] half_period
);

  logic [3:0] oct_cl;
  logic [1:0] shamt;

  always_comb begin
    sounding    = (octave != 4'd0) && (note >= KEY_C) && (note <= KEY_B);
    oct_cl      = octave;
    if (octave < OCT_MIN)      oct_cl = OCT_MIN;
    else if (octave > OCT_MAX) oct_cl = OCT_MAX;
    shamt       = 2'(oct_cl - OCT_MIN);
    half_period = '0;
    if (sounding) half_period = HP_W'(base_hp(4'(note - 16'd1)) >> shamt);
  end

endmodule

// File: rtl/rtttl_tone_gen.sv
// Square-wave speaker driver: restarts phase with a silent gap on every pitch change.
module rtttl_tone_gen
  import rtttl_pkg::*;
#(
  parameter int unsigned GAP_CYCLES = 2000,
  parameter int unsigned HP_W       = 11
) (
  input  logic            clk,
  input  logic            rstn,
  rtttl_tone_gen_if.slave bus
);

  localparam int unsigned GAP_W = 16;
  localparam logic [GAP_W-1:0] GAP_LAST = (GAP_CYCLES == 0) ? '0 : GAP_W'(GAP_CYCLES - 1);

  state_t            state, state_nx;
  logic [3:0]        cur_oct, oct_nx;
  logic [15:0]       cur_note, note_nx;
  logic [HP_W-1:0]   hp, hp_nx, hp_cnt, hp_cnt_nx;
  logic [GAP_W-1:0]  gap_cnt, gap_cnt_nx;
  logic              tone_q, tone_nx, active_q, active_nx;
  logic              lut_sounding;
  logic [HP_W-1:0]   lut_hp;
  logic              change;

  rtttl_pitch_lut #(.HP_W(HP_W)) u_lut (
    .octave      (bus.octave),
    .note        (bus.note),
    .sounding    (lut_sounding),
    .half_period (lut_hp)
  );

  assign change = {bus.octave, bus.note} != {cur_oct, cur_note};

  // Next-state and next-output logic; enable low beats change, change beats state progress.
  always_comb begin
    state_nx   = state;
    oct_nx     = cur_oct;
    note_nx    = cur_note;
    hp_nx      = hp;
    hp_cnt_nx  = hp_cnt;
    gap_cnt_nx = gap_cnt;
    tone_nx    = tone_q;
    if (!bus.enable) begin
      state_nx   = SILENT;
      tone_nx    = 1'b0;
      oct_nx     = 4'd0;
      note_nx    = 16'd0;
      hp_cnt_nx  = '0;
      gap_cnt_nx = '0;
    end else if (change) begin
      oct_nx     = bus.octave;
      note_nx    = bus.note;
      hp_nx      = lut_hp;
      hp_cnt_nx  = '0;
      gap_cnt_nx = '0;
      tone_nx    = 1'b0;
      if (!lut_sounding) begin
        state_nx = SILENT;
      end else if (GAP_CYCLES == 0) begin
        state_nx = PLAY;
        tone_nx  = 1'b1;
      end else begin
        state_nx = GAP;
      end
    end else begin
      case (state)
        GAP: begin
          tone_nx = 1'b0;
          if (gap_cnt == GAP_LAST) begin
            state_nx  = PLAY;
            tone_nx   = 1'b1;
            hp_cnt_nx = '0;
          end else begin
            gap_cnt_nx = gap_cnt + GAP_W'(1);
          end
        end
        PLAY: begin
          if (hp_cnt == hp - HP_W'(1)) begin
            hp_cnt_nx = '0;
            tone_nx   = ~tone_q;
          end else begin
            hp_cnt_nx = hp_cnt + HP_W'(1);
          end
        end
        default: begin
          state_nx = SILENT;
          tone_nx  = 1'b0;
        end
      endcase
    end
    active_nx = (state_nx == PLAY);
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state    <= SILENT;
      cur_oct  <= 4'd0;
      cur_note <= 16'd0;
      hp       <= '0;
      hp_cnt   <= '0;
      gap_cnt  <= '0;
      tone_q   <= 1'b0;
      active_q <= 1'b0;
    end else begin
      state    <= state_nx;
      cur_oct  <= oct_nx;
      cur_note <= note_nx;
      hp       <= hp_nx;
      hp_cnt   <= hp_cnt_nx;
      gap_cnt  <= gap_cnt_nx;
      tone_q   <= tone_nx;
      active_q <= active_nx;
    end
  end

  assign bus.tone_out    = tone_q;
  assign bus.tone_active = active_q;

endmodule

// File: tb/tb_rtttl_tone_gen.sv
// Bench for rtttl_tone_gen: elapsed-time reference model checked every cycle plus directed timing probes.
module tb_rtttl_tone_gen;

  localparam int GAP = 4;

  logic clk;
  logic rstn;
  rtttl_tone_gen_if bus ();

  rtttl_tone_gen #(.GAP_CYCLES(GAP), .HP_W(11)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  int base_tab [12] = '{1911, 1804, 1703, 1607, 1517, 1432, 1351, 1276, 1204, 1136, 1073, 1012};

  function automatic int ref_snd(input int o, input int n);
    return (o != 0 && n >= 1 && n <= 12) ? 1 : 0;
  endfunction

  function automatic int ref_hp(input int o, input int n);
    int co;
    if (ref_snd(o, n) == 0) return 0;
    co = (o < 4) ? 4 : ((o > 7) ? 7 : o);
    return base_tab[n-1] / (1 << (co - 4));
  endfunction

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      if (bad <= 40) $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: outputs are a pure function of cycles elapsed since the last accepted change.
  int m_oct = 0, m_note = 0, m_snd = 0, m_hp = 0;
  longint m_start = 0, edge_n = 0;

  always @(posedge clk) begin
    int exp_tone, exp_act;
    longint k, p;
    edge_n++;
    if (!rstn || !bus.enable) begin
      m_oct = 0; m_note = 0; m_snd = 0;
    end else if (int'(bus.octave) != m_oct || int'(bus.note) != m_note) begin
      m_oct   = int'(bus.octave);
      m_note  = int'(bus.note);
      m_snd   = ref_snd(m_oct, m_note);
      m_hp    = ref_hp(m_oct, m_note);
      m_start = edge_n;
    end
    #1;
    exp_tone = 0;
    exp_act  = 0;
    if (m_snd != 0) begin
      k = edge_n - m_start;
      if (k >= GAP) begin
        p        = k - GAP;
        exp_act  = 1;
        exp_tone = (((p / m_hp) % 2) == 0) ? 1 : 0;
      end
    end
    check("model_tone_out", int'(bus.tone_out), exp_tone);
    check("model_tone_active", int'(bus.tone_active), exp_act);
  end

  task automatic set_code(input int o, input int n);
    @(negedge clk);
    bus.octave = 4'(o);
    bus.note   = 16'(n);
  endtask

  // Edges from the change edge (index 0) until tone_out is first high.
  task automatic meas_rise(output int edges);
    edges = -1;
    for (int i = 0; i < 5000; i++) begin
      @(posedge clk); #1;
      if (bus.tone_out) begin edges = i; break; end
    end
  endtask

  // Edges until tone_out leaves level lvl.
  task automatic meas_level(input logic lvl, output int w);
    w = -1;
    for (int i = 1; i < 5000; i++) begin
      @(posedge clk); #1;
      if (bus.tone_out !== lvl) begin w = i; break; end
    end
  endtask

  task automatic probe(input string name, input int o, input int n, input int exp_hp);
    int r, w;
    set_code(o, n);
    meas_rise(r);
    check({name, "_rise"}, r, GAP);
    check({name, "_active"}, int'(bus.tone_active), 1);
    meas_level(1'b1, w);
    check({name, "_high"}, w, exp_hp);
    meas_level(1'b0, w);
    check({name, "_low"}, w, exp_hp);
  endtask

  task automatic rest_probe(input string name, input int o, input int n);
    int r;
    set_code(7, 10);
    meas_rise(r);
    repeat (20) @(posedge clk);
    set_code(o, n);
    @(posedge clk); #1;
    check({name, "_tone"}, int'(bus.tone_out), 0);
    check({name, "_active"}, int'(bus.tone_active), 0);
  endtask

  initial begin
    int r, w, sel, hold;
    rstn = 1'b0;
    bus.enable = 1'b1;
    bus.octave = 4'd0;
    bus.note   = 16'd0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_tone", int'(bus.tone_out), 0);
    check("reset_active", int'(bus.tone_active), 0);
    @(negedge clk) rstn = 1'b1;
    repeat (5) @(posedge clk);

    check("pin_hp_F5", ref_hp(5, 6), 716);
    check("pin_hp_Cs6", ref_hp(6, 2), 451);
    check("pin_hp_A7", ref_hp(7, 10), 142);
    check("pin_hp_A2", ref_hp(2, 10), 1136);
    check("pin_hp_A9", ref_hp(9, 10), 142);
    check("pin_snd_n13", ref_snd(4, 13), 0);

    probe("F5", 5, 6, 716);
    repeat (100) @(posedge clk);
    probe("Cs6", 6, 2, 451);
    probe("A7", 7, 10, 142);
    probe("A2", 2, 10, 1136);
    probe("A9", 9, 10, 142);

    rest_probe("rest_n0", 5, 0);
    rest_probe("rest_o0", 0, 6);
    rest_probe("rest_n13", 5, 13);
    rest_probe("rest_n106", 5, 16'h0106);

    // enable dropped for one cycle during PLAY restarts with a fresh gap
    set_code(4, 10);
    meas_rise(r);
    repeat (300) @(posedge clk);
    @(negedge clk) bus.enable = 1'b0;
    @(posedge clk); #1;
    check("en_low_tone", int'(bus.tone_out), 0);
    check("en_low_active", int'(bus.tone_active), 0);
    @(negedge clk) bus.enable = 1'b1;
    meas_rise(r);
    check("reen_rise", r, GAP);
    meas_level(1'b1, w);
    check("reen_high", w, 1136);

    // reset mid-GAP, then idle at rest
    set_code(5, 1);
    repeat (2) @(posedge clk);
    @(negedge clk) begin rstn = 1'b0; bus.octave = 4'd0; bus.note = 16'd0; end
    @(posedge clk); #1;
    check("rst_gap_tone", int'(bus.tone_out), 0);
    check("rst_gap_active", int'(bus.tone_active), 0);
    @(negedge clk) rstn = 1'b1;
    repeat (50) @(posedge clk); #1;
    check("rst_gap_idle", int'(bus.tone_active), 0);

    // reset mid-PLAY
    set_code(7, 10);
    meas_rise(r);
    repeat (60) @(posedge clk);
    @(negedge clk) begin rstn = 1'b0; bus.octave = 4'd0; bus.note = 16'd0; end
    @(posedge clk); #1;
    check("rst_play_tone", int'(bus.tone_out), 0);
    check("rst_play_active", int'(bus.tone_active), 0);
    @(negedge clk) rstn = 1'b1;
    repeat (50) @(posedge clk); #1;
    check("rst_play_idle", int'(bus.tone_active), 0);

    // random codes, repeats, enable pulses and occasional resets; the model checks every cycle
    for (int it = 0; it < 200; it++) begin
      sel  = int'($urandom_range(0, 11));
      hold = int'($urandom_range(1, 300));
      case (sel)
        0, 1, 2, 3, 4, 5: set_code(int'($urandom_range(1, 15)), int'($urandom_range(1, 12)));
        6: set_code(0, 0);
        7: set_code(0, int'($urandom_range(1, 12)));
        8: set_code(int'($urandom_range(1, 15)), int'($urandom_range(13, 65535)));
        9: begin
          @(negedge clk) bus.enable = 1'b0;
          repeat (int'($urandom_range(1, 3))) @(negedge clk);
          bus.enable = 1'b1;
        end
        10: @(negedge clk);
        default: begin
          @(negedge clk) rstn = 1'b0;
          @(negedge clk) rstn = 1'b1;
        end
      endcase
      repeat (hold) @(posedge clk);
    end

    repeat (5) @(posedge clk);
    #2;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
